// File: rtl/regfile_mp_scoreboard.sv
// Parametrised multi-port register file with write-to-read bypass, a per-register busy
// scoreboard for multi-cycle producers, and a sequential clear engine run after reset or on request.
module regfile_mp_scoreboard #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 ready,
    input  logic [NUM_RD*AW-1:0] ReadReg,
    output logic [NUM_RD*DW-1:0] ReadData,
    output logic [NUM_RD-1:0]    ReadBusy,
    input  logic                 WE,
    input  logic [AW-1:0]        WriteReg,
    input  logic [DW-1:0]        WriteData,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_reg
);
    localparam int DEPTH = 1 << AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]       state_reg;
    logic [AW-1:0]    clr_idx_reg;
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [DW-1:0]    mem [DEPTH];

    logic idle;
    logic wr_fire;
    logic iss_fire;
    logic wr_commit;

    assign idle  = (state_reg == ST_IDLE);
    assign ready = idle;

    // Fire terms drive the read bypass; commits additionally yield to a clear request.
    assign wr_fire   = idle && WE && (WriteReg != '0);
    assign iss_fire  = idle && issue_valid && (issue_reg != '0);
    assign wr_commit = wr_fire && !clr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
            busy_reg    <= '0;
        end else begin
            busy_reg <= busy_next;
            case (state_reg)
                ST_CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + 1'b1;
                    if (&clr_idx_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state_reg   <= ST_CLEAR;
                        clr_idx_reg <= '0;
                    end
                end
            endcase
        end
    end

    // Issue is applied after the write so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy_reg;
        if (!idle || clr_req) begin
            busy_next = '0;
        end else begin
            if (wr_fire) begin
                busy_next[WriteReg] = 1'b0;
            end
            if (iss_fire) begin
                busy_next[issue_reg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[clr_idx_reg] <= '0;
        end else if (wr_commit) begin
            mem[WriteReg] <= WriteData;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic [DW-1:0] arr_data;
            logic          hit;

            assign addr     = ReadReg[gi*AW +: AW];
            assign arr_data = (addr == '0) ? '0 : mem[addr];
            assign hit      = (BYPASS != 0) && wr_fire && (WriteReg == addr);

            assign ReadData[gi*DW +: DW] = !idle ? '0 :
                                           hit   ? WriteData : arr_data;
            assign ReadBusy[gi]          = !idle ? 1'b0 :
                                           hit   ? (iss_fire && (issue_reg == WriteReg)) :
                                                   busy_reg[addr];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: a BYPASS=1 and a BYPASS=0 instance share stimulus;
// a vector table covers single-cycle behaviour, hand sequences cover clear and reset corners.
module tb_regfile_mp_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic [9:0]  ReadReg = '0;
    logic        WE = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_reg = '0;

    logic        ready_b, ready_n;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.DW(32), .AW(5), .NUM_RD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b),
        .ReadReg(ReadReg), .ReadData(rd_data_b), .ReadBusy(rd_busy_b),
        .WE(WE), .WriteReg(WriteReg), .WriteData(WriteData),
        .issue_valid(issue_valid), .issue_reg(issue_reg)
    );

    regfile_mp_scoreboard #(.DW(32), .AW(5), .NUM_RD(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_n),
        .ReadReg(ReadReg), .ReadData(rd_data_n), .ReadBusy(rd_busy_n),
        .WE(WE), .WriteReg(WriteReg), .WriteData(WriteData),
        .issue_valid(issue_valid), .issue_reg(issue_reg)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        iss;
        logic [4:0]  ireg;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] nd0;
        logic        b0;
        logic        b1;
        logic        nb0;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clr_req     = 1'b0;
        WE          = 1'b0;
        WriteReg    = '0;
        WriteData   = '0;
        issue_valid = 1'b0;
        issue_reg   = '0;
    endtask

    // Counts samples with ready=0, starting right after the clear begins; optionally drives
    // writes, issues and a clr_req pulse that the clearing block must ignore.
    task automatic wait_ready(input string name, input bit noise);
        int cnt = 0;
        while (!ready_b && cnt < 100) begin
            cnt++;
            if (noise && cnt == 1) begin
                WE = 1'b1; WriteReg = 5'd3; WriteData = 32'h77;
                issue_valid = 1'b1; issue_reg = 5'd3;
            end
            if (noise && cnt == 5)  clr_req = 1'b1;
            if (noise && cnt == 6)  clr_req = 1'b0;
            if (noise && cnt == 30) idle_inputs();
            @(posedge clk);
            #1;
        end
        chk({name, "_cycles"}, 64'(cnt), 64'd32);
        chk({name, "_ready_n"}, {63'd0, ready_n}, 64'd1);
        $display("clear %s: ready after %0d cycles", name, cnt);
    endtask

    initial begin
        vt[0]  = '{1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd1, 5'd5, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd3, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 5'd7, 5'd1, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h12345678, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1};
        vt[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 5'd9, 32'h00001111, 1'b0, 5'd0, 5'd9, 5'd7, 32'h00001111, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b1};

        // Reset and power-up clear
        ReadReg = {5'd31, 5'd5};
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", {63'd0, ready_b}, 64'd0);
        chk("reset_busy", {62'd0, rd_busy_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready("powerup", 1'b0);
        chk("powerup_data", rd_data_b, 64'd0);
        chk("powerup_busy", {62'd0, rd_busy_b}, 64'd0);

        // Single-cycle behaviour, checked before each edge
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            WE = vt[i].we; WriteReg = vt[i].wreg; WriteData = vt[i].wdata;
            issue_valid = vt[i].iss; issue_reg = vt[i].ireg;
            ReadReg = {vt[i].r1, vt[i].r0};
            #1;
            $display("vec %0d: we=%0b wreg=%0d iss=%0b ireg=%0d rd=%0d/%0d -> 0x%0h/0x%0h busy=%b",
                     i, vt[i].we, vt[i].wreg, vt[i].iss, vt[i].ireg, vt[i].r0, vt[i].r1,
                     rd_data_b[31:0], rd_data_b[63:32], rd_busy_b);
            chk($sformatf("v%0d_d0", i), {32'd0, rd_data_b[31:0]}, {32'd0, vt[i].d0});
            chk($sformatf("v%0d_d1", i), {32'd0, rd_data_b[63:32]}, {32'd0, vt[i].d1});
            chk($sformatf("v%0d_b0", i), {63'd0, rd_busy_b[0]}, {63'd0, vt[i].b0});
            chk($sformatf("v%0d_b1", i), {63'd0, rd_busy_b[1]}, {63'd0, vt[i].b1});
            chk($sformatf("v%0d_nb_d0", i), {32'd0, rd_data_n[31:0]}, {32'd0, vt[i].nd0});
            chk($sformatf("v%0d_nb_b0", i), {63'd0, rd_busy_n[0]}, {63'd0, vt[i].nb0});
        end
        @(negedge clk);
        idle_inputs();

        // clr_req together with a write: write dropped, outputs gated while clearing
        clr_req = 1'b1; WE = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
        ReadReg = {5'd9, 5'd7};
        @(posedge clk);
        #1;
        idle_inputs();
        chk("clr_gate_data", rd_data_b, 64'd0);
        chk("clr_gate_busy", {62'd0, rd_busy_b}, 64'd0);
        wait_ready("clr_req", 1'b1);
        @(negedge clk);
        ReadReg = {5'd7, 5'd3};
        #1;
        chk("clr_reg3_reg7", rd_data_b, 64'd0);
        chk("clr_busy", {62'd0, rd_busy_b}, 64'd0);
        chk("clr_nb_data", rd_data_n, 64'd0);

        // Reset at clear cycle 10
        @(negedge clk);
        WE = 1'b1; WriteReg = 5'd12; WriteData = 32'hBEEF;
        @(negedge clk);
        idle_inputs();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midclr_rst_ready", {63'd0, ready_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready("midclr_rst", 1'b0);
        for (int r = 0; r < 32; r += 2) begin
            @(negedge clk);
            ReadReg = {5'(r + 1), 5'(r)};
            #1;
            chk($sformatf("sweep_data_%0d", r), rd_data_b, 64'd0);
            chk($sformatf("sweep_busy_%0d", r), {62'd0, rd_busy_b}, 64'd0);
        end

        // Reset in mid-operation: busy and array both come back zero
        @(negedge clk);
        WE = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD;
        issue_valid = 1'b1; issue_reg = 5'd6;
        @(negedge clk);
        idle_inputs();
        ReadReg = {5'd6, 5'd5};
        #1;
        chk("preop_data5", {32'd0, rd_data_b[31:0]}, 64'hDEAD);
        chk("preop_busy6", {63'd0, rd_busy_b[1]}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midop_rst_ready", {63'd0, ready_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready("midop_rst", 1'b0);
        chk("midop_data5", {32'd0, rd_data_b[31:0]}, 64'd0);
        chk("midop_busy6", {62'd0, rd_busy_b}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
